// File: rtl/clk_div_bank_if.sv
// clk_div_bank_if: configuration write bus of the divider bank, with its error response
interface clk_div_bank_if #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 16
);
    localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1;
    logic             we;
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic             err;
    modport master (output we, ch, period, high, input err);
    modport slave  (input we, ch, period, high, output err);
endinterface

// File: rtl/clk_div_bank.sv
// clk_div_bank: multi-channel programmable clock divider with tick strobes and boundary-aligned reconfiguration
module clk_div_bank #(
    parameter int N_CH       = 2,
    parameter int CNT_W      = 16,
    parameter int DEF_PERIOD = 134,
    parameter int DEF_HIGH   = 67
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic [N_CH-1:0] en_i,
    input  logic            sync_i,
    clk_div_bank_if.slave   cfg,
    output logic [N_CH-1:0] clk_o,
    output logic [N_CH-1:0] tick_o,
    output logic [N_CH-1:0] pend_o
);
    localparam int CH_W = N_CH > 1 ? $clog2(N_CH) : 1;
    logic cfg_ok;
    // A write is accepted only for an existing channel with P >= 2 and 1 <= H < P
    always_comb cfg_ok = cfg.we && int'(cfg.ch) < N_CH && cfg.period >= CNT_W'(2) &&
                         cfg.high != '0 && cfg.high < cfg.period;
    // Rejected writes raise a one-cycle error pulse after the write edge
    always_ff @(posedge clk_i or negedge rst_n_i)
        if (!rst_n_i) cfg.err <= 1'b0;
        else          cfg.err <= cfg.we && !cfg_ok;
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [CNT_W-1:0] p, h, sp, sh, cnt;
        logic [CNT_W-1:0] p_n, h_n, cnt_n;
        logic             pend, wr, run, wrap, apply, clk_q, tick_q;
        // Boundary detection: sync or a counter wrap; a disabled channel applies its shadow at once
        always_comb begin
            wr    = cfg_ok && cfg.ch == CH_W'(c);
            run   = en_i[c];
            wrap  = run && (sync_i || cnt >= p - CNT_W'(1));
            apply = pend && (wrap || !run);
            p_n   = apply ? sp : p;
            h_n   = apply ? sh : h;
            cnt_n = !run ? p_n - CNT_W'(1) : wrap ? '0 : cnt + CNT_W'(1);
        end
        // Channel state; a write on a boundary edge only reaches the shadow
        always_ff @(posedge clk_i or negedge rst_n_i)
            if (!rst_n_i) begin
                p      <= CNT_W'(DEF_PERIOD);
                h      <= CNT_W'(DEF_HIGH);
                sp     <= CNT_W'(DEF_PERIOD);
                sh     <= CNT_W'(DEF_HIGH);
                cnt    <= CNT_W'(DEF_PERIOD - 1);
                pend   <= 1'b0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                p      <= p_n;
                h      <= h_n;
                cnt    <= cnt_n;
                sp     <= wr ? cfg.period : sp;
                sh     <= wr ? cfg.high : sh;
                pend   <= wr || (pend && !apply);
                clk_q  <= run && cnt_n < h_n;
                tick_q <= wrap;
            end
        assign clk_o[c]  = clk_q;
        assign tick_o[c] = tick_q;
        assign pend_o[c] = pend;
    end
endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Programmable multi-channel clock/tick generator for the audio equalizer datapath. It derives N_CH independent divided clocks from the 100 MHz system clock, for example the ~746 kHz converter clock and sample-rate strobes. Each channel has a runtime-programmable period and high time, a per-channel enable, and a matching one-cycle tick strobe. Reconfiguration is glitch-free and takes effect only at a period boundary. A global sync input phase-aligns all channels.

## Interface
- N_CH, 2, number of divider channels (1..8)
- CNT_W, 16, counter/period width in bits
- DEF_PERIOD, 134, reset period of every channel in clk_i cycles
- DEF_HIGH, 67, reset high time of every channel in clk_i cycles
- CH_W (localparam), max(1, clog2(N_CH)), channel-select width

- clk_i  in  1  system clock (100 MHz)
- rst_n_i  in  1  reset, asynchronous, active-low
- en_i  in  N_CH  per-channel run enable
- sync_i  in  1  one-cycle pulse; restarts all enabled channels in phase
- cfg_we_i  in  1  config write strobe
- cfg_ch_i  in  CH_W  channel addressed by the write
- cfg_period_i  in  CNT_W  new period P in cycles
- cfg_high_i  in  CNT_W  new high time H in cycles
- clk_o  out  N_CH  divided clocks, registered
- tick_o  out  N_CH  one-cycle strobe at each period start
- pend_o  out  N_CH  shadow config waiting to be applied
- err_o  out  1  one-cycle pulse: last write rejected

## Operation
- Per channel registers:
  - active P, H
  - shadow P, H
  - pending flag
  - counter cnt (CNT_W)
- Reset values:
  - P = DEF_PERIOD, H = DEF_HIGH; shadows equal actives
  - cnt = DEF_PERIOD-1, pending = 0
  - clk_o = 0, tick_o = 0, pend_o = 0, err_o = 0
- Config write validity: cfg_ch_i < N_CH, P ≥ 2, 1 ≤ H ≤ P-1.
  - Valid write: loads shadow, sets pending.
  - Invalid write: ignored; err_o = 1 next cycle.
  - A second write before apply overwrites the shadow.
- Disabled channel (en_i = 0):
  - cnt held at P-1; clk_o = 0; tick_o = 0.
  - A pending shadow is applied on the next edge; cnt follows the new P-1.
- Enabled channel, per edge:
  - Wrap: if cnt == P-1, next cnt = 0; otherwise cnt+1.
  - clk_o <= (next cnt < H).
  - tick_o <= wrap.
  - On wrap with pending set: P, H <= shadow and pending clears in that same edge. The new H governs the cycle in which cnt = 0.
- The first enabled edge after disable always wraps, so the output starts with a full high phase and a tick.
- sync_i: every enabled channel is treated as wrapping on that edge (cnt <= 0, tick, pending applied), regardless of cnt. Disabled channels ignore sync_i.
- Priority within one edge: reset > sync > normal wrap > count.
  - A write in the same cycle as a wrap or sync lands in the shadow only. It is applied at the following boundary, not the current one.
- All outputs come directly from flops; no combinational path from inputs to outputs.

## Timing
- Config write to apply: at the first wrap or sync at least one edge after the write. Worst case P+1 cycles.
- clk_o period = P cycles, high for H cycles. tick_o rises together with clk_o's rising edge.
- en_i rise at edge k: clk_o = 1 and tick_o = 1 after edge k.
- en_i fall: clk_o = 0 after the same edge. A partial high phase is truncated, which is allowed.
- err_o and pend_o update one edge after cfg_we_i.
- Asynchronous reset mid-period: outputs clear immediately. After release, the counter restarts from the defaults.

## Test plan
- Reset, en_i = 01: ch0 clk_o period 134, high 67; tick_o every 134 cycles aligned to the rise; ch1 stays 0.
- Write ch0 P = 10, H = 3 mid-period: pend_o[0] = 1 until the next wrap. The old 134/67 waveform completes, then a 10/3 waveform follows; pend_o clears on the apply edge.
- Invalid writes, then pend_o/shadow check:
  - Writes: P = 1; H = 0; H = P; cfg_ch_i = N_CH.
  - Each gives a single-cycle err_o pulse.
  - pend_o and shadow stay unchanged.
- Both channels enabled, ch0 P = 6, ch1 P = 9, random phase; pulse sync_i: both tick_o on the next edge, cnt = 0; rises coincide every 18 cycles.
- Write in the exact wrap cycle: new values are not used for that period; they apply at the next wrap.
- Disabled channel with pending write: applies on the next edge. Then en_i = 1 gives an immediate tick and the new waveform. Toggling rst_n_i mid-run clears all outputs asynchronously.
